// File: rtl/biquad8_coeff_loader_if.sv
// Host write/commit bus and filter coefficient stream of the biquad coefficient loader.
// Width parameters must match the loader instance attached through the slave modport.
interface biquad8_coeff_loader_if #(
  parameter int CWIDTH   = 18,
  parameter int ADDRBITS = 4
);
  logic                wr_en_i;
  logic [ADDRBITS-1:0] wr_addr_i;
  logic [CWIDTH-1:0]   wr_dat_i;
  logic                commit_i;
  logic                busy_o;
  logic                done_o;
  logic                wr_reject_o;
  logic [CWIDTH-1:0]   coeff_dat_o;
  logic                coeff_wr_o;
  logic                coeff_update_o;

  modport slave (
    input  wr_en_i, wr_addr_i, wr_dat_i, commit_i,
    output busy_o, done_o, wr_reject_o, coeff_dat_o, coeff_wr_o, coeff_update_o
  );

  modport master (
    output wr_en_i, wr_addr_i, wr_dat_i, commit_i,
    input  busy_o, done_o, wr_reject_o, coeff_dat_o, coeff_wr_o, coeff_update_o
  );
endinterface

// File: rtl/biquad8_coeff_loader.sv
// Shadow-buffered coefficient loader: streams NCOEFF words, highest index first, into a
// DSP B-cascade chain with a strobe every other cycle, then fires a single update strobe.
module biquad8_coeff_loader #(
  parameter int NCOEFF   = 12,
  parameter int CWIDTH   = 18,
  parameter int ADDRBITS = 4
) (
  input logic clk,
  input logic rst,
  biquad8_coeff_loader_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_HOLD, S_UPDATE, S_DONE} state_t;

  localparam logic [ADDRBITS-1:0] LAST_IDX = ADDRBITS'(NCOEFF - 1);

  state_t              r_state;
  state_t              w_next;
  logic [CWIDTH-1:0]   r_shadow [NCOEFF];
  logic [ADDRBITS-1:0] r_idx;
  logic                r_pend;
  logic                r_reject;

  logic w_load;
  logic w_step;
  logic w_busy;
  logic w_wr;
  logic w_upd;
  logic w_done;
  logic w_addr_ok;
  logic w_wr_ok;

  assign w_addr_ok = ({1'b0, bus.wr_addr_i} < (ADDRBITS + 1)'(NCOEFF));
  assign w_wr_ok   = bus.wr_en_i && !w_busy && w_addr_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_busy = 1'b0;
    w_wr   = 1'b0;
    w_upd  = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.commit_i || r_pend) begin
          w_next = S_SHIFT;
          w_load = 1'b1;
        end
      end
      S_SHIFT: begin
        w_busy = 1'b1;
        w_wr   = 1'b1;
        w_next = S_HOLD;
      end
      S_HOLD: begin
        w_busy = 1'b1;
        if (r_idx == '0) begin
          w_next = S_UPDATE;
        end else begin
          w_next = S_SHIFT;
          w_step = 1'b1;
        end
      end
      S_UPDATE: begin
        w_busy = 1'b1;
        w_upd  = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        // A queued commit keeps the loader busy straight into the next sequence
        w_busy = r_pend;
        if (r_pend || bus.commit_i) begin
          w_next = S_SHIFT;
          w_load = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx    <= '0;
      r_pend   <= 1'b0;
      r_reject <= 1'b0;
      for (int i = 0; i < NCOEFF; i++) r_shadow[i] <= '0;
    end else begin
      r_reject <= bus.wr_en_i && (w_busy || !w_addr_ok);
      if (w_wr_ok) r_shadow[bus.wr_addr_i] <= bus.wr_dat_i;
      if (w_load)      r_idx <= LAST_IDX;
      else if (w_step) r_idx <= r_idx - ADDRBITS'(1);
      if (w_load)                     r_pend <= 1'b0;
      else if (bus.commit_i && w_busy) r_pend <= 1'b1;
    end
  end

  // Buffer is write-locked while busy, so the selected word holds from strobe to next strobe
  assign bus.coeff_dat_o    = r_shadow[r_idx];
  assign bus.coeff_wr_o     = w_wr;
  assign bus.coeff_update_o = w_upd;
  assign bus.busy_o         = w_busy;
  assign bus.done_o         = w_done;
  assign bus.wr_reject_o    = r_reject;

endmodule

// File: doc/biquad8_coeff_loader.md
BIQUAD8_COEFF_LOADER -- requirements
Module: biquad8_coeff_loader

Interface
REQ-001 Parameter NCOEFF, default 12, SHALL set the number of coefficient words per load (length of the DSP B-cascade shift chain).
REQ-002 Parameter CWIDTH, default 18, SHALL set the coefficient word width.
REQ-003 Parameter ADDRBITS, default 4, SHALL set the host address width (2**ADDRBITS >= NCOEFF).
REQ-004 clk  input  1  sole clock; all logic rising-edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 wr_en_i  input  1  host write strobe to the shadow buffer.
REQ-007 wr_addr_i  input  ADDRBITS  shadow buffer index.
REQ-008 wr_dat_i  input  CWIDTH  shadow buffer write data.
REQ-009 commit_i  input  1  single-cycle request to load the shadow buffer into the filter.
REQ-010 busy_o  output  1  high while a load sequence is in progress.
REQ-011 done_o  output  1  single-cycle pulse at load completion.
REQ-012 wr_reject_o  output  1  single-cycle pulse when a host write is discarded.
REQ-013 coeff_dat_o  output  CWIDTH  coefficient word to the filter.
REQ-014 coeff_wr_o  output  1  shift strobe to the filter B1 chain.
REQ-015 coeff_update_o  output  1  transfer strobe to the filter B2 registers.

Function
REQ-016 Shadow buffer SHALL be NCOEFF x CWIDTH flops, written on wr_en_i when not busy and wr_addr_i < NCOEFF.
REQ-017 A write with wr_addr_i >= NCOEFF, or any write while busy_o=1, SHALL be discarded and pulse wr_reject_o the following cycle.
REQ-018 FSM states SHALL be IDLE, SHIFT, HOLD, UPDATE, DONE.
REQ-019 IDLE->SHIFT on commit_i (or pending commit); busy_o SHALL assert the cycle after commit_i.
REQ-020 A write and commit_i in the same IDLE cycle SHALL both be honored, with the written value included in the load.
REQ-021 Words SHALL be emitted in descending index NCOEFF-1 down to 0, so index 0 ends in the first DSP.
REQ-022 In SHIFT, coeff_wr_o=1 for exactly one cycle with coeff_dat_o = current word; HOLD follows, with coeff_wr_o=0 and coeff_dat_o unchanged.
REQ-023 Strobes SHALL be spaced 2 cycles apart: for commit_i at cycle t, coeff_wr_o is high at t+1, t+3, ..., t+2*NCOEFF-1.
REQ-024 coeff_dat_o SHALL remain stable from each strobe cycle through the next strobe cycle, so a consumer registering the strobe by one cycle samples the correct word.
REQ-025 After the final HOLD, UPDATE SHALL drive coeff_update_o=1 for one cycle at t+2*NCOEFF+1.
REQ-026 DONE SHALL pulse done_o at t+2*NCOEFF+2; busy_o SHALL deassert the same cycle.
REQ-027 commit_i while busy SHALL set a single pending flag (multiple commits collapse); DONE SHALL then go to SHIFT with busy_o held high and the next strobe at DONE+1.
REQ-028 Word index counter SHALL count down from NCOEFF-1 and never wrap; reaching 0 in HOLD SHALL select UPDATE.
REQ-029 Outside SHIFT, coeff_wr_o SHALL be 0; outside UPDATE, coeff_update_o SHALL be 0.

Reset
REQ-030 rst SHALL asynchronously force IDLE, clear the pending flag, zero the shadow buffer, and zero all outputs.
REQ-031 rst mid-sequence SHALL abort without asserting coeff_update_o; the filter's active coefficients are left unchanged.

Verification
REQ-032 Write i*3+1 to addresses 0..11, commit at t -> 12 strobes at t+1..t+23 odd, data 34,31,...,1; update at t+25; done at t+26.
REQ-033 Write addr 12 in IDLE -> wr_reject_o at next cycle; buffer unchanged; a subsequent load shows original contents.
REQ-034 Commit at t, commit again at t+4 and t+6 -> one additional sequence only, first strobe at t+27, busy_o continuously high t+1..t+51.
REQ-035 Write addr 11=0x3FFFF together with commit_i -> first strobe data 0x3FFFF.
REQ-036 Assert rst at t+9 of a load -> all outputs 0 immediately, no coeff_update_o; buffer reads 0 on next commit.
REQ-037 Write during busy -> wr_reject_o pulse; streamed data matches pre-commit buffer contents.
